bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/bus_arb_timer.sv | 25 ++
 rtl/bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_bus_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    localparam logic        OWNER_IFU = 1'b0;
    localparam logic        OWNER_LSU = 1'b1;
    localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/bus_arb_timer.sv
// Memory-wait watchdog: counts cycles while a transaction is outstanding and
// flags expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module bus_arb_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    // Cleared when a grant is issued, advances every outstanding cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        r_cnt <= '0;
        else if (i_clear) r_cnt <= '0;
        else if (i_run)   r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = i_run && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester (IFU fetch, LSU load/store) arbiter onto one memory port.
// One transaction in flight; LSU wins ties. Optional watchdog enabled by
// defining BUS_ARB_TIMEOUT_EN; without it REQ/WAIT wait indefinitely.
module bus_arbiter import bus_arb_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_req_ready,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_req_ready,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        arb_busy,
    output logic        arb_owner,
    output logic        bus_err
);
    if (TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t  r_state;
    logic        r_owner;
    logic [31:0] r_addr;
    logic        r_wen;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic [31:0] r_rdata;
    logic        r_err;

    logic w_idle;
    logic w_lsu_grant;
    logic w_ifu_grant;
    logic w_timeout;

    // Grants are combinational so the ready pulse lines up with the request
    // in the IDLE cycle; reset masks them so outputs drop immediately.
    assign w_idle      = !rst && (r_state == IDLE);
    assign w_lsu_grant = w_idle && lsu_req_valid;
    assign w_ifu_grant = w_idle && ifu_req_valid && !lsu_req_valid;

`ifdef BUS_ARB_TIMEOUT_EN
    bus_arb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clear   (w_lsu_grant || w_ifu_grant),
        .i_run     ((r_state == REQ) || (r_state == WAIT)),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // Arbitration FSM: latch the winner's request, drive memory, return data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= OWNER_IFU;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_err <= 1'b0;
                    if (lsu_req_valid) begin
                        r_owner <= OWNER_LSU;
                        r_addr  <= lsu_addr;
                        r_wen   <= lsu_wen;
                        r_wdata <= lsu_wdata;
                        r_wmask <= lsu_wmask;
                        r_state <= REQ;
                    end else if (ifu_req_valid) begin
                        r_owner <= OWNER_IFU;
                        r_addr  <= ifu_addr;
                        r_wen   <= 1'b0;
                        r_wdata <= '0;
                        r_wmask <= '0;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        r_state <= WAIT;
                    end else if (w_timeout) begin
                        r_rdata <= ERR_RDATA;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        r_rdata <= mem_rdata;
                        r_state <= RESP;
                    end else if (w_timeout) begin
                        r_rdata <= ERR_RDATA;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ifu_req_ready  = w_ifu_grant;
    assign lsu_req_ready  = w_lsu_grant;

    assign mem_req_valid  = (r_state == REQ);
    assign mem_addr       = r_addr;
    assign mem_wen        = r_wen;
    assign mem_wdata      = r_wdata;
    assign mem_wmask      = r_wmask;

    assign ifu_resp_valid = (r_state == RESP) && (r_owner == OWNER_IFU);
    assign lsu_resp_valid = (r_state == RESP) && (r_owner == OWNER_LSU);
    assign ifu_rdata      = ifu_resp_valid ? r_rdata : 32'h0;
    assign lsu_rdata      = lsu_resp_valid ? r_rdata : 32'h0;

    assign arb_busy       = (r_state != IDLE);
    assign arb_owner      = r_owner;
    assign bus_err        = (r_state == RESP) && r_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed stimulus pushes expected memory
// requests and requester responses; a negedge monitor pops and compares.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wmask = '0;
    logic        lsu_req_ready, lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_wen;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        arb_busy, arb_owner, bus_err;

    typedef struct packed {
        logic        lsu;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mreq_t;

    resp_t rq[$];
    mreq_t mq[$];
    int    n_checks = 0;
    int    n_err    = 0;

    bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_addr(ifu_addr),
        .ifu_req_ready(ifu_req_ready), .ifu_resp_valid(ifu_resp_valid),
        .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_req_ready(lsu_req_ready), .lsu_resp_valid(lsu_resp_valid),
        .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .arb_busy(arb_busy), .arb_owner(arb_owner), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response and every memory handshake must match the head
    // of its queue; anything arriving with an empty queue is unexpected.
    always @(negedge clk) begin
        if (ifu_resp_valid || lsu_resp_valid) begin
            if (rq.size() == 0) begin
                chk("unexpected_resp", 128'({ifu_resp_valid, lsu_resp_valid}), 128'(0));
            end else begin
                resp_t e;
                e = rq.pop_front();
                chk("resp", 128'({lsu_resp_valid, ifu_resp_valid, ifu_rdata, lsu_rdata, bus_err}),
                    128'({e.lsu, !e.lsu, e.lsu ? 32'h0 : e.rdata, e.lsu ? e.rdata : 32'h0, e.err}));
            end
        end
        if (mem_req_valid && mem_req_ready) begin
            if (mq.size() == 0) begin
                chk("unexpected_mem_req", 128'(mem_addr), 128'(0));
                if (mem_addr == 32'h0) n_err++;
            end else begin
                mreq_t m;
                m = mq.pop_front();
                chk("mem_req", 128'({mem_addr, mem_wen, mem_wdata, mem_wmask}),
                    128'({m.addr, m.wen, m.wdata, m.wmask}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state with requests pending: everything must stay quiet.
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; mem_resp_valid = 1'b1;
        #3;
        chk("reset_outputs", 128'({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
                                   mem_req_valid, arb_busy, arb_owner, bus_err, mem_addr, mem_wen}), 128'(0));
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_resp_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // IFU read, minimum latency.
        tick();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1; #1;
        chk("t1_ifu_ready", 128'({ifu_req_ready, lsu_req_ready}), 128'(2'b10));
        mq.push_back('{32'h8000_0000, 1'b0, 32'h0, 4'h0});
        rq.push_back('{1'b0, 32'h0000_0413, 1'b0});
        tick(); ifu_req_valid = 1'b0; ifu_addr = '0; #1;
        chk("t1_req", 128'({mem_req_valid, arb_busy, arb_owner, ifu_req_ready}), 128'(4'b1100));
        tick(); mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413; #1;
        chk("t1_wait_no_resp", 128'({ifu_resp_valid, mem_req_valid}), 128'(0));
        tick(); mem_resp_valid = 1'b0; mem_rdata = '0; #1;
        chk("t1_latency", 128'({ifu_resp_valid, lsu_resp_valid, ifu_rdata}), 128'({2'b10, 32'h0000_0413}));
        tick(); #1;
        chk("t1_idle", 128'({arb_busy, ifu_resp_valid}), 128'(0));

        // Simultaneous requests: LSU store first, IFU on the next IDLE.
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b1111; #1;
        chk("t2_tie_ready", 128'({lsu_req_ready, ifu_req_ready}), 128'(2'b10));
        mq.push_back('{32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b1111});
        rq.push_back('{1'b1, 32'h1234_5678, 1'b0});
        tick(); lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0; #1;
        chk("t2_lsu_req", 128'({ifu_req_ready, arb_owner, mem_wen, mem_req_valid}), 128'(4'b0111));
        tick(); mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678; #1;
        tick(); mem_resp_valid = 1'b0; #1;
        chk("t2_ifu_held_off", 128'({ifu_req_ready, lsu_resp_valid}), 128'(2'b01));
        tick(); #1;
        chk("t2_ifu_grant", 128'(ifu_req_ready), 128'(1));
        mq.push_back('{32'h8000_0004, 1'b0, 32'h0, 4'h0});
        rq.push_back('{1'b0, 32'h0000_0013, 1'b0});
        tick(); ifu_req_valid = 1'b0; #1;
        chk("t2_ifu_owner", 128'({arb_owner, mem_req_valid}), 128'(2'b01));
        tick(); mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0013;
        tick(); mem_resp_valid = 1'b0;
        tick();

        // Memory stalls the request for five cycles; fields must hold.
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2004; lsu_wen = 1'b1;
        lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 4'b0011; mem_req_ready = 1'b0; #1;
        chk("t3_grant", 128'(lsu_req_ready), 128'(1));
        mq.push_back('{32'h8000_2004, 1'b1, 32'hCAFE_F00D, 4'b0011});
        rq.push_back('{1'b1, 32'hA5A5_A5A5, 1'b0});
        for (int i = 0; i < 6; i++) begin
            tick();
            lsu_req_valid = 1'b0; lsu_addr = '1; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
            mem_req_ready = (i == 5); #1;
            chk("t3_stall", 128'({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask}),
                128'({1'b1, 32'h8000_2004, 1'b1, 32'hCAFE_F00D, 4'b0011}));
        end
        tick(); mem_resp_valid = 1'b1; mem_rdata = 32'hA5A5_A5A5; #1;
        chk("t3_wait", 128'({mem_req_valid, arb_busy}), 128'(2'b01));
        tick(); mem_resp_valid = 1'b0; #1;
        chk("t3_resp", 128'({lsu_resp_valid, lsu_rdata}), 128'({1'b1, 32'hA5A5_A5A5}));
        tick();

        // Reset in WAIT, then a late memory response after release.
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
        mq.push_back('{32'h8000_0010, 1'b0, 32'h0, 4'h0});
        tick(); ifu_req_valid = 1'b0;
        tick(); #1;
        chk("t4_in_wait", 128'({arb_busy, mem_req_valid}), 128'(2'b10));
        rst = 1'b1; #1;
        chk("t4_async_reset", 128'({arb_busy, mem_req_valid, ifu_resp_valid, arb_owner}), 128'(0));
        tick(); tick(); rst = 1'b0;
        tick();
        tick(); mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0BAD; #1;
        chk("t4_late_resp", 128'({arb_busy, ifu_resp_valid, lsu_resp_valid}), 128'(0));
        tick(); mem_resp_valid = 1'b0; #1;
        chk("t4_quiet", 128'({arb_busy, ifu_resp_valid, lsu_resp_valid}), 128'(0));

        // LSU pulses a request during WAIT and withdraws it.
        tick(); ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0020;
        mq.push_back('{32'h8000_0020, 1'b0, 32'h0, 4'h0});
        rq.push_back('{1'b0, 32'h0000_0093, 1'b0});
        tick(); ifu_req_valid = 1'b0;
        tick(); lsu_req_valid = 1'b1; lsu_addr = 32'h9000_0000; #1;
        chk("t5_no_grant_in_wait", 128'(lsu_req_ready), 128'(0));
        tick(); lsu_req_valid = 1'b0; lsu_addr = '0; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0093; #1;
        chk("t5_still_no_grant", 128'(lsu_req_ready), 128'(0));
        tick(); mem_resp_valid = 1'b0;
        tick(); #1;
        chk("t5_idle", 128'({arb_busy, mem_req_valid}), 128'(0));
        tick(); #1;
        chk("t5_idle2", 128'({arb_busy, mem_req_valid}), 128'(0));

        // Memory never responds.
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0030;
        mq.push_back('{32'h8000_0030, 1'b0, 32'h0, 4'h0});
`ifdef BUS_ARB_TIMEOUT_EN
        rq.push_back('{1'b0, 32'h0, 1'b1});
`endif
        tick(); ifu_req_valid = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        for (int k = 2; k <= 8; k++) begin
            tick(); #1;
            chk("t6_waiting", 128'({ifu_resp_valid, bus_err, arb_busy}), 128'(3'b001));
        end
        tick(); #1;
        chk("t6_timeout", 128'({ifu_resp_valid, lsu_resp_valid, bus_err, ifu_rdata}), 128'({3'b101, 32'h0}));
        tick(); #1;
        chk("t6_after", 128'({arb_busy, bus_err}), 128'(0));
`else
        for (int k = 0; k < 20; k++) begin
            tick(); #1;
            chk("t6_hang", 128'({ifu_resp_valid, bus_err, arb_busy}), 128'(3'b001));
        end
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        chk("t6_recover", 128'(arb_busy), 128'(0));
`endif

        tick(); tick();
        chk("sb_resp_drained", 128'(rq.size()), 128'(0));
        chk("sb_mem_drained", 128'(mq.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
